gate_vector_checker: RTL
========================

# gate_vector_checker

Synthesizable stimulus/response engine for 2-input gate-under-test (GUT) blocks in the gates-conversion library. On `start` it drives all four input combinations in order 00, 01, 10, 11. After a configurable settle time it samples the GUT output for each vector and compares the captured truth table against an expected one. It reports the result as pass, mismatch count and the observed table, so gate-equivalence checks run in hardware instead of relying on a simulation-only monitor.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: idle cycles between driving a vector and sampling `y_in`. Legal range 0..255.
- `EXPECT`, default 4'b1000 (AND): expected truth table. Bit index = {a,b}.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a check run. Sampled only in IDLE.
- `y_in` input 1: GUT output, combinational from `a_out`/`b_out`, same clock domain.
- `a_out` output 1: GUT input a.
- `b_out` output 1: GUT input b.
- `busy` output 1: high while a run is in progress.
- `done` output 1: one-cycle pulse when a run completes.
- `pass` output 1: `observed == EXPECT`. Valid from `done`; held until next start.
- `mismatch_count` output 3: number of differing bits between `observed` and `EXPECT`, 0..4.
- `observed` output 4: captured truth table. Bit {a,b} holds the `y_in` sample for that vector.

## Operation
- FSM states:
  - IDLE: `busy`=0, `a_out`=`b_out`=0.
  - RUN: walks the vectors.
- IDLE, `start`=1: go to RUN.
  - vector index `idx` is set to 0.
  - `a_out`,`b_out` = 0,0.
  - settle counter is loaded with `SETTLE_CYCLES`.
  - `observed`, `mismatch_count` and `pass` clear to 0.
  - `busy`=1.
- RUN, each edge with counter ≠ 0: decrement the counter.
- RUN, edge with counter = 0:
  - `observed[idx]` <= `y_in`.
  - `mismatch_count` increments if `y_in` ≠ `EXPECT[idx]`.
  - If `idx` < 3: increment `idx`, drive `a_out`=`idx[1]`, `b_out`=`idx[0]` of the new index, reload the counter.
  - If `idx` = 3: go to IDLE, `busy`=0, `done`=1 for one cycle, `pass` = (final mismatch count = 0).
- `start` while RUN is ignored and the run continues unaffected.
- `start` in the cycle `done` is high is accepted, because the FSM is already in IDLE. The new run clears the results.
- `mismatch_count` saturates naturally at 4. It cannot overflow 3 bits.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `mismatch_count`=0, `observed`=0, `a_out`=0, `b_out`=0, FSM=IDLE, `idx`=0, counter=0.
- All outputs are registered. There is no combinational path from `y_in` or `start` to any output.
- Per-vector time is `SETTLE_CYCLES`+1 cycles.
  - If `start` is accepted at edge E, vector k is driven from edge E+k·(S+1).
  - Vector k is sampled at edge E+(k+1)·(S+1).
  - `done` rises at edge E+4·(S+1). With the defaults that is E+12.
  - With `SETTLE_CYCLES`=0, `done` rises at E+4.
- `y_in` is sampled at a sampling edge using the value present in the preceding cycle. The GUT has at least S+1 cycles to settle.
- `rst` mid-run:
  - At the next edge all state returns to reset values and the run is abandoned.
  - `done` does not pulse.
  - Stale results are cleared.
- `rst` has priority over `start` in the same cycle.

## Structure
- Package `gate_check_pkg` holds:
  - the FSM state encoding (IDLE, RUN);
  - truth-table constants `TT_AND`=4'b1000, `TT_NAND`=4'b0111, `TT_OR`=4'b1110, `TT_NOR`=4'b0001, `TT_XOR`=4'b0110, `TT_XNOR`=4'b1001;
  - a `popcount4` function.
- One sub-module, `gate_settle_timer`:
  - loadable down-counter of width $clog2(SETTLE_CYCLES+1), minimum 1;
  - inputs `load`, `en`; output `zero`.
- The top level holds the FSM, the index counter and the result registers.

## Test plan
- GUT = NAND-built AND, `EXPECT`=`TT_AND`, S=2; `start` at edge E:
  - `a_out`/`b_out` step 00→01→10→11 at E, E+3, E+6, E+9;
  - `done` at E+12;
  - `observed`=1000, `mismatch_count`=0, `pass`=1.
- `y_in` tied to 1, `EXPECT`=`TT_AND`: `observed`=1111, `mismatch_count`=3, `pass`=0.
- GUT = XOR, `EXPECT`=`TT_XOR`, S=0: `done` exactly 4 cycles after `start`, `pass`=1.
- `start` re-pulsed at E+5 during a run: ignored, `done` still at E+12 with unchanged results.
- `rst` asserted at E+7:
  - next edge shows all outputs 0 and no `done`;
  - a following `start` completes a full correct run.
- `start` held high through `done`: a second run begins on the `done` cycle, results clear, `done` again 12 cycles later.

Source files
------------

// File: rtl/gate_vector_checker_pkg.sv
// ============================================================================
// Module      : gate_check_pkg
// Description : Shared types, truth-table constants and helpers for the
//               2-input gate vector checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_check_pkg;

  // FSM state encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Truth tables, bit index = {a,b}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  // Number of set bits in a 4-bit vector (0..4)
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_vector_checker_if.sv
// ============================================================================
// Module      : gate_vector_checker_if
// Description : Control, GUT drive/response and result bundle of the gate
//               vector checker. master = controller/GUT side, slave = checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gate_vector_checker_if;
  logic       start;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] mismatch_count;
  logic [3:0] observed;

  modport master (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, mismatch_count, observed
  );

  modport slave (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, mismatch_count, observed
  );
endinterface

`default_nettype wire

// File: rtl/gate_settle_timer.sv
// ============================================================================
// Module      : gate_settle_timer
// Description : Loadable down-counter that spaces vector drive and sampling.
//               zero is high once the loaded settle time has elapsed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  // A settle time of 0 still needs a 1-bit counter
  localparam int              c_width = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [c_width-1:0] c_load = c_width'(SETTLE_CYCLES);

  logic [c_width-1:0] r_count;

  // Load has priority; otherwise count down and stick at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= c_load;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - c_width'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/gate_vector_checker.sv
// ============================================================================
// Module      : gate_vector_checker
// Description : Drives the four input combinations of a 2-input gate under
//               test, samples its output after a settle time and compares the
//               captured truth table against EXPECT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_vector_checker
  import gate_check_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT        = TT_AND
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_vector_checker_if.slave  bus
);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_idx;
  logic [1:0] w_idx_next;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_mismatch;
  logic [3:0] r_observed;
  logic [3:0] w_obs_next;
  logic       w_miss;
  logic       w_timer_load;
  logic       w_timer_en;
  logic       w_timer_zero;
  logic       w_accept;
  logic       w_sample;
  logic       w_last;

  gate_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (w_timer_load),
    .en   (w_timer_en),
    .zero (w_timer_zero)
  );

  assign w_idx_next = r_idx + 2'd1;
  assign w_miss     = (bus.y_in != EXPECT[r_idx]);

  // Observed table as it will look once the current sample is captured
  always_comb begin
    w_obs_next        = r_observed;
    w_obs_next[r_idx] = bus.y_in;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-edge control strobes
  always_comb begin
    w_state_next = r_state;
    w_timer_load = 1'b0;
    w_timer_en   = 1'b0;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_RUN;
          w_accept     = 1'b1;
          w_timer_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_timer_zero) begin
          w_sample = 1'b1;
          if (r_idx == 2'd3) begin
            w_last       = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_timer_load = 1'b1;
          end
        end else begin
          w_timer_en = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Vector index, GUT drive and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= 2'd0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_mismatch <= 3'd0;
      r_observed <= 4'd0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_idx      <= 2'd0;
        r_a        <= 1'b0;
        r_b        <= 1'b0;
        r_busy     <= 1'b1;
        r_pass     <= 1'b0;
        r_mismatch <= 3'd0;
        r_observed <= 4'd0;
      end
      if (w_sample) begin
        r_observed <= w_obs_next;
        r_mismatch <= r_mismatch + {2'b00, w_miss};
        if (w_last) begin
          // Run complete: release the GUT inputs back to the idle pattern
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_a    <= 1'b0;
          r_b    <= 1'b0;
          r_pass <= (popcount4(w_obs_next ^ EXPECT) == 3'd0);
        end else begin
          r_idx <= w_idx_next;
          r_a   <= w_idx_next[1];
          r_b   <= w_idx_next[0];
        end
      end
    end
  end

  assign bus.a_out          = r_a;
  assign bus.b_out          = r_b;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.mismatch_count = r_mismatch;
  assign bus.observed       = r_observed;

endmodule

`default_nettype wire
